// File: rtl/serial_subtractor_if.sv
// ----------------------------------------------------------------------------
// serial_subtractor_if
//   Start/done handshake and operand/result bundle for the bit-serial
//   subtractor.
//
//   Signals
//     start       requester -> subtractor : request; accepted only while idle
//     a           requester -> subtractor : minuend, captured on accept
//     b           requester -> subtractor : subtrahend, captured on accept
//     busy        subtractor -> requester : operation in flight (SHIFT/DONE)
//     done        subtractor -> requester : one-cycle pulse, results valid
//     diff        subtractor -> requester : a - b mod 2^WIDTH
//     borrow_out  subtractor -> requester : unsigned a < b
//     ovf         subtractor -> requester : signed overflow of a - b
//
//   Modports
//     master : the requester (drives start/a/b)
//     slave  : the subtractor (drives busy/done/results)
// ----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             ovf;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  diff,
        input  borrow_out,
        input  ovf
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output diff,
        output borrow_out,
        output ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor, diff = a - b, LSB first, one bit
//   per clock. A single full-subtractor cell plus a registered borrow is
//   sequenced by a three-state FSM (IDLE -> SHIFT x WIDTH -> DONE -> IDLE).
//
//   Ports
//     clk   in  rising-edge clock
//     rst   in  synchronous, active-high reset (aborts any operation)
//     bus   slave modport of serial_subtractor_if:
//             start/a/b in, busy/done/diff/borrow_out/ovf out
//
//   Timing
//     start accepted at edge N -> done high in the cycle after edge N+WIDTH.
//     busy is high for WIDTH+1 cycles. Results are held until the next
//     accepted operation completes; partial results never reach diff.
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int              CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
        logic d;
        logic bout;
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
        return {bout, d};
    endfunction

    // Signed overflow of a - b: operand signs differ and the result sign
    // differs from the minuend sign.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_bw;
    logic [CNT_W-1:0] r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;

    logic [1:0]       w_fs;
    logic             w_bw_next;
    logic [WIDTH-1:0] w_res_next;

    // The cell works on the current LSBs; the new difference bit enters the
    // result register at the MSB so that after WIDTH shifts bit 0 lands at 0.
    always_comb begin
        w_fs       = full_sub(r_sa[0], r_sb[0], r_bw);
        w_bw_next  = w_fs[1];
        w_res_next = {w_fs[0], r_res[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_bw     <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_res   <= '0;
                        r_bw    <= 1'b0;
                        r_cnt   <= '0;
                        r_a_msb <= bus.a[WIDTH-1];
                        r_b_msb <= bus.b[WIDTH-1];
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_bw  <= w_bw_next;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Results are published from the final bit's combinational
                    // value so they are registered and valid during DONE.
                    if (r_cnt == CNT_LAST) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_diff   <= w_res_next;
                        r_borrow <= w_bw_next;
                        r_ovf    <= sub_ovf(r_a_msb, r_b_msb, w_res_next[WIDTH-1]);
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow;
    assign bus.ovf        = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int MASK  = (1 << WIDTH) - 1;
    localparam int LAT   = WIDTH + 1;

    logic clk;
    logic rst;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // m_left: cycles of busy still ahead after the current edge (0 = idle).
    int m_left = 0;
    int m_a, m_b;
    int m_diff = 0, m_bor = 0, m_ovf = 0;
    int m_ops = 0;

    function automatic int to_signed(input int v);
        return (v >= (1 << (WIDTH - 1))) ? v - (1 << WIDTH) : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_diff = 0;
            m_bor  = 0;
            m_ovf  = 0;
        end else if (m_left == 0) begin
            if (bus.start === 1'b1) begin
                m_a    = int'(bus.a);
                m_b    = int'(bus.b);
                m_left = LAT;
                m_ops++;
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                int sd;
                sd     = to_signed(m_a) - to_signed(m_b);
                m_diff = (m_a - m_b) & MASK;
                m_bor  = (m_a < m_b) ? 1 : 0;
                m_ovf  = (sd > (1 << (WIDTH - 1)) - 1 || sd < -(1 << (WIDTH - 1))) ? 1 : 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic chk_en = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(bus.busy), (m_left > 0) ? 1 : 0);
            check("done", int'(bus.done), (m_left == 1) ? 1 : 0);
            check("diff", int'(bus.diff), m_diff);
            check("borrow_out", int'(bus.borrow_out), m_bor);
            check("ovf", int'(bus.ovf), m_ovf);
            if (bus.done === 1'b1)
                check("done_pulse", int'(prev_done), 0);
        end
        prev_done = bus.done;
    end

    // ---------------- directed helpers ----------------
    task automatic do_op(input int av, input int bv, input int ed, input int eb,
                         input int eo, input string nm);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av[WIDTH-1:0];
        bus.b     = bv[WIDTH-1:0];
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, "_latency"}, cyc, LAT);
        check({nm, "_diff"}, int'(bus.diff), ed);
        check({nm, "_borrow"}, int'(bus.borrow_out), eb);
        check({nm, "_ovf"}, int'(bus.ovf), eo);
        @(negedge clk);
    endtask

    initial begin
        int busy_cnt;
        int cyc;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_diff", int'(bus.diff), 0);
        check("rst_borrow", int'(bus.borrow_out), 0);
        rst = 1'b0;

        // hand-computed literal expectations
        do_op(100, 37, 63, 0, 0, "t1");
        do_op(5, 9, 252, 1, 0, "t2a");
        do_op(8'h80, 8'h01, 8'h7F, 0, 1, "t2b");
        do_op(8'hA5, 8'hA5, 0, 0, 0, "t3a");
        do_op(0, 8'hFF, 8'h01, 1, 0, "t3b");
        do_op(8'h3C, 0, 8'h3C, 0, 0, "b_zero");

        // start held high with changing operands while busy
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd100;
        bus.b     = 8'd37;
        busy_cnt  = 0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                check("hold_diff", int'(bus.diff), 63);
                check("hold_borrow", int'(bus.borrow_out), 0);
            end
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
        end
        bus.start = 1'b0;
        check("hold_busy_cycles", busy_cnt, LAT);
        @(negedge clk);
        check("hold_idle", int'(bus.busy), 0);

        // reset in the middle of shifting
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd200;
        bus.b     = 8'd17;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_diff", int'(bus.diff), 0);
        check("abort_borrow", int'(bus.borrow_out), 0);
        check("abort_ovf", int'(bus.ovf), 0);
        repeat (12) @(negedge clk);
        check("abort_no_done", int'(bus.done), 0);
        do_op(8'h7F, 8'h80, 8'hFF, 1, 1, "post_abort");

        // randomized traffic, start toggled freely (also while busy)
        m_ops = 0;
        cyc   = 0;
        while (m_ops < 1000 && cyc < 40000) begin
            int sel;
            @(negedge clk);
            cyc++;
            sel       = int'($urandom_range(0, 9));
            bus.start = ($urandom_range(0, 1) == 1);
            bus.a     = 8'($urandom);
            bus.b     = (sel == 0) ? bus.a : (sel == 1) ? 8'h00 : 8'($urandom);
        end
        bus.start = 1'b0;
        check("random_ops_reached", (m_ops >= 1000) ? 1 : 0, 1);
        repeat (LAT + 3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
